instr_prefetch_buffer: RTL
==========================

Name: instr_prefetch_buffer

Overview:
Instruction-side prefetch stage directly upstream of the pipelined RV32 core's fetch input. It issues sequential word fetches to a variable-latency instruction memory over a req/gnt/rvalid bus and buffers returned words with their PCs in a small FIFO. It presents them to the core over a valid/ready handshake and flushes on control-flow redirects from the core's execute stage.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max granted-but-unreturned requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  async active-low reset
redirect_i  in  1  core redirect (taken branch/jump), one cycle
redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0)
ready_i  in  1  core accepts head entry (= !stall_f)
valid_o  out  1  head entry valid
instr_o  out  32  head instruction; 32'h0000_0013 (NOP) when !valid_o
pc_o  out  32  PC of head instruction; 0 when !valid_o
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid; responses return in request order, >=1 cycle after gnt
imem_rdata_i  in  32  response data

Behaviour:
- Reset (async): FIFO empty, all slots = NOP/PC 0. fetch_addr=RESET_PC. outstanding=0, discard=0, state=RUN, started=0. Outputs: valid_o=0, instr_o=32'h13, pc_o=0, imem_req_o=0, imem_addr_o=RESET_PC.
- started sets on the first clock edge after reset release; imem_req_o is gated by started.
- State machine:
  - RUN: imem_req_o = started && (count + outstanding < DEPTH) && outstanding < MAX_OUTSTANDING. imem_addr_o = fetch_addr.
  - DRAIN: imem_req_o=0. Entered on redirect when stale requests remain. Returns to RUN on the edge where discard reaches 0.
- Grant: req&&gnt at an edge -> outstanding+1, fetch_addr+4. The PC is pushed into an internal PC queue of MAX_OUTSTANDING entries. fetch_addr wraps mod 2^32.
- Response: rvalid at an edge -> outstanding-1.
  - If discard>0: discard-1 and the data is dropped.
  - Otherwise push {rdata, queued PC} into the FIFO; valid_o rises the next cycle (no fall-through).
- Pop: valid_o&&ready_i at an edge -> head advances. instr_o/pc_o are driven combinationally from the head entry.
- Redirect (highest priority) at an edge:
  - Flush the FIFO (valid_o=0 next cycle); any same-cycle pop is ignored.
  - fetch_addr={redirect_pc_i[31:2],2'b00}.
  - discard = outstanding after this edge's grant/response updates. This counts a same-edge grant as stale and a same-edge rvalid as already consumed.
  - A same-edge rvalid is dropped, never pushed.
  - An ungranted request (req&&!gnt) is withdrawn; the memory contract permits withdrawal.
  - Next state = DRAIN if discard>0, else RUN.
- Redirect while in DRAIN: reload fetch_addr; discard is unchanged apart from normal decrements.
- Simultaneous push and pop with the FIFO full: legal. Space reservation guarantees no overflow.
- Unsolicited rvalid (outstanding=0): ignored, no push.
- Latency: with 1-cycle memory and an idle core, the first valid_o is 3 cycles after reset release (req, rvalid, FIFO visible). Sustained throughput is 1 instr/cycle when MAX_OUTSTANDING>=2 and gnt is always high.
- Address/req signals are stable while req&&!gnt, unless a redirect occurs.

Test Plan:
- Reset release, gnt=1, 1-cycle rvalid, ready=1, memory returns addr^32'hA5A5_0000 -> req at cycles 1,2,3…, addresses 0,4,8…. valid_o from cycle 3; pc_o 0,4,8 on consecutive cycles; no gaps.
- ready=0 held, DEPTH=4 -> exactly 4 grants, then req=0 with FIFO full. Raising ready for 1 cycle pops pc 0 and produces exactly one new request at 0x10.
- Redirect to 0x0000_0102 with 2 outstanding (3-cycle latency) -> valid_o=0 next cycle, state DRAIN, 2 responses dropped. First new req addr=0x100; first valid pc_o=0x100.
- Redirect on the same edge as rvalid and pop with the FIFO holding 0x20,0x24 -> rvalid data not pushed, pop ignored, FIFO empty, discard = remaining outstanding.
- gnt=0 for 5 cycles -> imem_addr_o held at 0x8; then redirect to 0x40 -> request withdrawn, next req addr 0x40, discard=0, state stays RUN.
- Async reset asserted mid-stream (FIFO 3 entries, 2 outstanding) -> outputs immediately at reset values. After release, fetch restarts at RESET_PC; late rvalids are ignored.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches over a req/gnt/rvalid bus
// and queues {instr, pc} pairs for the core, flushing on execute-stage redirects.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t        state, state_next;
    logic          started;
    logic [31:0]   fetch_addr;
    logic [OW-1:0] outstanding, outstanding_next;
    logic [OW-1:0] discard, discard_next;

    entry_t        fifo [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    // PCs of granted-but-unreturned requests, consumed in order as responses arrive
    logic [31:0]   pcq [MAX_OUTSTANDING];
    logic [QW-1:0] pcq_rd, pcq_wr;

    logic grant, resp, push, pop, room;

    function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] idx);
        return (idx == QW'(MAX_OUTSTANDING - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Space is reserved for every in-flight response, so a push can never overflow
    assign room = (32'(count) + 32'(outstanding) < DEPTH) &&
                  (32'(outstanding) < MAX_OUTSTANDING);

    always_comb begin
        imem_req_o = 1'b0;
        if (state == RUN)
            imem_req_o = started && room;
    end

    assign grant            = imem_req_o & imem_gnt_i;
    assign resp             = imem_rvalid_i & (outstanding != '0);
    assign push             = resp & (discard == '0) & ~redirect_i;
    assign pop              = valid_o & ready_i & ~redirect_i;
    assign outstanding_next = outstanding + OW'(grant) - OW'(resp);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= RUN;
        else
            state <= state_next;
    end

    // A same-edge grant is already stale and a same-edge response already consumed
    always_comb begin
        state_next   = state;
        discard_next = discard;
        if (resp && (discard != '0))
            discard_next = discard - 1'b1;
        case (state)
            RUN: begin
                if (redirect_i) begin
                    discard_next = outstanding_next;
                    if (outstanding_next != '0)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (discard_next == '0)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            started     <= 1'b0;
            fetch_addr  <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++)
                pcq[i] <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (redirect_i)
                fetch_addr <= redirect_pc_i & 32'hFFFF_FFFC;
            else if (grant)
                fetch_addr <= fetch_addr + 32'd4;
            if (grant) begin
                pcq[pcq_wr] <= fetch_addr;
                pcq_wr      <= pcq_inc(pcq_wr);
            end
            if (resp)
                pcq_rd <= pcq_inc(pcq_rd);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++)
                fifo[i] <= '{instr: NOP, pc: 32'h0};
        end else if (redirect_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{instr: imem_rdata_i, pc: pcq[pcq_rd]};
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign valid_o     = (count != '0);
    assign instr_o     = valid_o ? fifo[rd_ptr].instr : NOP;
    assign pc_o        = valid_o ? fifo[rd_ptr].pc : 32'h0;
    assign imem_addr_o = fetch_addr;

endmodule
